// File: rtl/pea_drain_if.sv
`default_nettype none
// ============================================================================
// Module   : pea_drain_if
// Purpose  : Paired result/status word handshake from the output drain to host.
// Revision : 1.0 - initial release
// ============================================================================
interface pea_drain_if #(
  parameter int width = 32
);
  logic             out_valid;
  logic             out_ready;
  logic [width-1:0] out_result;
  logic [width-1:0] out_status;

  modport master (
    output out_valid,
    output out_result,
    output out_status,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_result,
    input  out_status,
    output out_ready
  );
endinterface
`default_nettype wire

// File: rtl/pea_output_drain.sv
`default_nettype none
// ============================================================================
// Module   : pea_output_drain
// Purpose  : Pops result/status FIFO pairs and presents them to the host.
// Revision : 1.0 - initial release
// ============================================================================
module pea_output_drain #(
  parameter int width           = 32,
  parameter int buffer_size_out = 32
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               invoke,
  input  logic                               drain_all,
  input  logic [$clog2(buffer_size_out)-1:0] result_pop,
  input  logic [$clog2(buffer_size_out)-1:0] status_pop,
  input  logic [width-1:0]                   result_data,
  input  logic [width-1:0]                   status_data,
  output logic                               rd_en_result,
  output logic                               rd_en_status,
  output logic                               enable,
  output logic                               FC,
  output logic [15:0]                        pair_count,
  pea_drain_if.master                        host
);

  localparam int c_pop_w = $clog2(buffer_size_out);
  localparam int c_rem_w = c_pop_w + 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_POP     = 3'd1,
    S_LATCH   = 3'd2,
    S_PRESENT = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [c_rem_w-1:0]   r_remaining;
  logic [width-1:0]     r_out_result;
  logic [width-1:0]     r_out_status;
  logic [15:0]          r_pair_count;
  logic                 w_pops_ok;
  logic [c_pop_w-1:0]   w_min_pop;
  logic                 w_xfer;

  assign w_pops_ok = (result_pop != '0) && (status_pop != '0);
  assign w_min_pop = (result_pop < status_pop) ? result_pop : status_pop;
  assign w_xfer    = (r_state == S_PRESENT) && host.out_ready;

  assign enable          = (r_state == S_IDLE) && w_pops_ok;
  assign host.out_result = r_out_result;
  assign host.out_status = r_out_status;
  assign pair_count      = r_pair_count;

  // Pops are re-checked on every POP entry so a firing ends early if a FIFO ran dry.
  always_comb begin
    w_next         = r_state;
    rd_en_result   = 1'b0;
    rd_en_status   = 1'b0;
    host.out_valid = 1'b0;
    FC             = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (invoke && w_pops_ok) w_next = S_POP;
      end
      S_POP: begin
        if (w_pops_ok) begin
          rd_en_result = 1'b1;
          rd_en_status = 1'b1;
          w_next       = S_LATCH;
        end else begin
          w_next = S_DONE;
        end
      end
      S_LATCH: begin
        w_next = S_PRESENT;
      end
      S_PRESENT: begin
        host.out_valid = 1'b1;
        if (host.out_ready) w_next = (r_remaining != '0) ? S_POP : S_DONE;
      end
      S_DONE: begin
        FC     = 1'b1;
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_remaining  <= '0;
      r_out_result <= '0;
      r_out_status <= '0;
      r_pair_count <= '0;
    end else begin
      r_state <= w_next;
      // The pair budget is a snapshot; later upstream writes do not extend it.
      if ((r_state == S_IDLE) && (w_next == S_POP))
        r_remaining <= drain_all ? {1'b0, w_min_pop} : c_rem_w'(1);
      if (r_state == S_LATCH) begin
        r_out_result <= result_data;
        r_out_status <= status_data;
        r_remaining  <= r_remaining - c_rem_w'(1);
      end
      if (w_xfer)
        r_pair_count <= r_pair_count + 16'd1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pea_output_drain.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_pea_output_drain
// Purpose  : Scoreboard bench with FIFO model for pea_output_drain.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pea_output_drain;

  typedef struct packed {
    logic [31:0] r;
    logic [31:0] s;
  } pair_t;

  logic        clk         = 1'b0;
  logic        rst_n       = 1'b0;
  logic        invoke      = 1'b0;
  logic        drain_all   = 1'b0;
  logic [4:0]  result_pop  = 5'd0;
  logic [4:0]  status_pop  = 5'd0;
  logic [31:0] result_data = 32'd0;
  logic [31:0] status_data = 32'd0;
  logic        rd_en_result;
  logic        rd_en_status;
  logic        enable;
  logic        FC;
  logic [15:0] pair_count;

  pea_drain_if #(.width(32)) host ();

  pea_output_drain #(.width(32), .buffer_size_out(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .invoke       (invoke),
    .drain_all    (drain_all),
    .result_pop   (result_pop),
    .status_pop   (status_pop),
    .result_data  (result_data),
    .status_data  (status_data),
    .rd_en_result (rd_en_result),
    .rd_en_status (rd_en_status),
    .enable       (enable),
    .FC           (FC),
    .pair_count   (pair_count),
    .host         (host)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] rq[$];
  logic [31:0] sq[$];
  pair_t       exp_q[$];
  pair_t       mon_e;
  logic [15:0] model_pairs = 16'd0;
  int          fc_cnt = 0;
  int          str_r  = 0;
  int          str_s  = 0;
  int          ready_mode = 1;
  int          fc0, sr0, ss0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [4:0] sat(input int n);
    return (n > 31) ? 5'd31 : 5'(n);
  endfunction

  // Upstream FIFOs: read data appears the cycle after the strobe, counts are registered.
  always @(posedge clk) begin
    if (rd_en_result && rq.size() > 0) result_data <= rq.pop_front();
    if (rd_en_status && sq.size() > 0) status_data <= sq.pop_front();
    result_pop <= sat(rq.size());
    status_pop <= sat(sq.size());
  end

  initial begin
    host.out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      host.out_ready = (ready_mode == 2) ? 1'($urandom_range(0, 1)) : (ready_mode == 1);
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (FC) fc_cnt++;
      if (rd_en_result) str_r++;
      if (rd_en_status) str_s++;
      if (host.out_valid && host.out_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_transfer: got 0x%0h/0x%0h, required no transfer",
                   host.out_result, host.out_status);
        end else begin
          mon_e = exp_q.pop_front();
          chk("transfer_pair", {host.out_result, host.out_status}, {mon_e.r, mon_e.s});
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input int nr, input int ns);
    for (int i = 0; i < nr; i++) rq.push_back($urandom);
    for (int i = 0; i < ns; i++) sq.push_back($urandom);
  endtask

  // Reference: a firing delivers the front min(pops) pairs (or one) seen at invoke.
  task automatic start_fire(input bit da, output int n);
    fc0 = fc_cnt;
    sr0 = str_r;
    ss0 = str_s;
    @(negedge clk);
    if (result_pop == 0 || status_pop == 0) n = 0;
    else if (da) n = (result_pop < status_pop) ? int'(result_pop) : int'(status_pop);
    else n = 1;
    chk("enable_idle", enable, (n > 0));
    for (int i = 0; i < n; i++) exp_q.push_back({rq[i], sq[i]});
    model_pairs = model_pairs + 16'(n);
    invoke    = 1'b1;
    drain_all = da;
    @(negedge clk);
    invoke    = 1'b0;
    drain_all = 1'($urandom_range(0, 1));
  endtask

  task automatic finish_fire(input int n);
    int k;
    k = 0;
    if (n > 0) begin
      while (fc_cnt == fc0 && k < 4000) begin
        @(negedge clk);
        k++;
      end
      if (fc_cnt == fc0) begin
        n_cmp++;
        n_err++;
        $display("FAIL fc_timeout: got no FC after %0d cycles, required FC", k);
      end
    end else begin
      idle(8);
    end
    idle(2);
    chk("fc_count", 64'(fc_cnt - fc0), 64'(n > 0));
    chk("strobes_result", 64'(str_r - sr0), 64'(n));
    chk("strobes_status", 64'(str_s - ss0), 64'(n));
    chk("pair_count", pair_count, model_pairs);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  task automatic fire(input bit da, input int er, input int es, input bit intrude);
    int n;
    start_fire(da, n);
    push(er, es);
    if (intrude && n > 0) begin
      @(negedge clk);
      invoke    = 1'b1;
      drain_all = 1'b1;
      @(negedge clk);
      invoke    = 1'b0;
    end
    finish_fire(n);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int    n, k, nr, ns;
    pair_t hold;

    idle(3);
    chk("reset_out_valid", host.out_valid, 1'b0);
    chk("reset_rd_en", {rd_en_result, rd_en_status}, 2'b00);
    chk("reset_fc", FC, 1'b0);
    chk("reset_data", {host.out_result, host.out_status}, 64'd0);
    chk("reset_pair_count", pair_count, 16'd0);
    rst_n = 1'b1;
    idle(2);

    // Single pair latency: rd_en at cycle 1, out_valid at 3, FC at 4.
    ready_mode = 1;
    rq.push_back(32'h5);
    sq.push_back(32'h1);
    idle(2);
    start_fire(1'b0, n);
    chk("lat_rd_en_c1", {rd_en_result, rd_en_status}, 2'b11);
    chk("lat_valid_c1", host.out_valid, 1'b0);
    @(negedge clk);
    chk("lat_rd_en_c2", {rd_en_result, rd_en_status}, 2'b00);
    @(negedge clk);
    chk("lat_valid_c3", host.out_valid, 1'b1);
    chk("lat_data_c3", {host.out_result, host.out_status}, {32'h5, 32'h1});
    @(negedge clk);
    chk("lat_fc_c4", FC, 1'b1);
    chk("lat_valid_c4", host.out_valid, 1'b0);
    finish_fire(n);

    // Status FIFO empty: invoke ignored, then one pair once status arrives.
    push(2, 0);
    idle(2);
    fire(1'b0, 0, 0, 1'b0);
    push(0, 1);
    idle(2);
    fire(1'b0, 0, 0, 1'b0);

    // Three pairs drained in one firing.
    push(2, 3);
    idle(2);
    fire(1'b1, 0, 0, 1'b0);

    // Host stalls for 10 cycles in PRESENT.
    ready_mode = 0;
    push(1, 1);
    idle(2);
    start_fire(1'b0, n);
    hold = exp_q[0];
    k = 0;
    while (!host.out_valid && k < 10) begin
      @(negedge clk);
      k++;
    end
    for (int i = 0; i < 10; i++) begin
      chk("stall_valid", host.out_valid, 1'b1);
      chk("stall_data", {host.out_result, host.out_status}, {hold.r, hold.s});
      @(negedge clk);
    end
    chk("stall_strobes", 64'(str_r - sr0), 64'd1);
    ready_mode = 1;
    finish_fire(n);

    // Reset mid-firing with two pairs still owed.
    ready_mode = 0;
    push(3, 3);
    idle(2);
    start_fire(1'b1, n);
    k = 0;
    while (!host.out_valid && k < 10) begin
      @(negedge clk);
      k++;
    end
    idle(2);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", host.out_valid, 1'b0);
    chk("midrst_rd_en", {rd_en_result, rd_en_status}, 2'b00);
    chk("midrst_fc", FC, 1'b0);
    chk("midrst_data", {host.out_result, host.out_status}, 64'd0);
    chk("midrst_pair_count", pair_count, 16'd0);
    exp_q.delete();
    model_pairs = 16'd0;
    idle(2);
    rst_n = 1'b1;
    ready_mode = 2;
    sr0 = str_r;
    idle(10);
    chk("postrst_no_strobe", 64'(str_r - sr0), 64'd0);
    chk("postrst_fifo_r", 64'(rq.size()), 64'd2);
    chk("postrst_fifo_s", 64'(sq.size()), 64'd2);
    fire(1'b1, 0, 0, 1'b0);

    // Randomized firings with concurrent pushes and ignored invokes.
    for (int it = 0; it < 30; it++) begin
      ready_mode = int'($urandom_range(1, 2));
      nr = int'($urandom_range(0, 6));
      ns = int'($urandom_range(0, 6));
      if (rq.size() + nr > 26) nr = 0;
      if (sq.size() + ns > 26) ns = 0;
      push(nr, ns);
      idle(2);
      fire(1'($urandom_range(0, 1)),
           (rq.size() < 26) ? int'($urandom_range(0, 2)) : 0,
           (sq.size() < 26) ? int'($urandom_range(0, 2)) : 0,
           ($urandom_range(0, 2) == 0));
    end

    // Counter wrap from 0xFFFF.
    ready_mode = 1;
    rq.delete();
    sq.delete();
    idle(3);
    force dut.r_pair_count = 16'hFFFF;
    @(negedge clk);
    release dut.r_pair_count;
    model_pairs = 16'hFFFF;
    push(2, 2);
    idle(2);
    fire(1'b0, 0, 0, 1'b0);
    chk("wrap_zero", pair_count, 16'h0000);
    fire(1'b0, 0, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
